// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register that parks a fetched instruction while decode is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        full_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        full_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Clear takes priority so a redirect always empties the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, one-outstanding imem handshake, stall buffer
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_address,
  output logic        valid
);
  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;

  logic         buf_full;
  logic         buf_load;
  logic         buf_clear;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc;

  logic         grant;
  logic         resp;
  logic         unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .instr_i (imem_rdata),
    .pc_i    (out_pc_q),
    .full_o  (buf_full),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  // A new request may chase a completing response in WAIT, giving one fetch per cycle.
  always_comb begin
    imem_req = 1'b0;
    if (!rst && !redirect && !buf_full) begin
      case (state_q)
        REQ:     imem_req = 1'b1;
        WAIT:    imem_req = imem_rvalid && !stall;
        default: imem_req = 1'b0;
      endcase
    end
  end

  assign grant     = imem_req && imem_gnt;
  assign resp      = (state_q == WAIT) && imem_rvalid;
  assign buf_load  = !redirect && stall && resp;
  assign buf_clear = redirect || (!stall && buf_full);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_pc_d   = out_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    if (redirect) begin
      // A request still in flight leaves us in DROP so its response is thrown away.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      case (state_q)
        WAIT, DROP: state_d = imem_rvalid ? REQ : DROP;
        default:    state_d = REQ;
      endcase
    end else begin
      if (grant) begin
        out_pc_d   = fetch_pc_q;
        fetch_pc_d = next_word(fetch_pc_q);
      end

      case (state_q)
        REQ:     if (grant) state_d = WAIT;
        WAIT:    if (imem_rvalid) state_d = grant ? WAIT : REQ;
        DROP:    if (imem_rvalid) state_d = REQ;
        default: state_d = REQ;
      endcase

      if (!stall) begin
        if (buf_full) begin
          instr_d = buf_instr;
          pc_d    = buf_pc;
          valid_d = 1'b1;
        end else if (resp) begin
          instr_d = imem_rdata;
          pc_d    = out_pc_q;
          valid_d = 1'b1;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      out_pc_q   <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign pc_address  = pc_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based memory plus a transaction-level
// model of the instruction stream decode should see.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_address;
  logic        valid;

  int compared;
  int mismatched;

  logic [31:0] memQ[$];
  int          memWait;
  int          gntProb;
  int          latMin;
  int          latMax;

  logic [31:0] expFetch;
  logic [31:0] expInstr;
  logic [31:0] expPc;
  logic        expValid;
  bit          mSquash;
  logic [31:0] bufInstrQ[$];
  logic [31:0] bufPcQ[$];

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_address  (pc_address),
    .valid       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check32("valid", {31'b0, valid}, {31'b0, expValid});
    check32("instruction", instruction, expInstr);
    check32("pc_address", pc_address, expPc);
  endtask

  task automatic clearModel();
    memQ.delete();
    memWait   = 0;
    expFetch  = RPC;
    expInstr  = NOP;
    expPc     = RPC;
    expValid  = 1'b0;
    mSquash   = 1'b0;
    bufInstrQ.delete();
    bufPcQ.delete();
  endtask

  task automatic doReset();
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    clearModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset imem_req", {31'b0, imem_req}, 32'd0);
    check32("reset imem_addr", imem_addr, RPC);
    checkOutput();
    rst = 1'b0;
  endtask

  // One clock: drive inputs at the negedge, step memory and model on the posedge.
  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] rpc);
    bit          rvNow;
    bit          gnt;
    bit          reqExp;
    bit          reqAct;
    bit          respGood;
    logic [31:0] headPc;
    logic [31:0] addrAct;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    rvNow       = (memQ.size() > 0) && (memWait == 0);
    headPc      = rvNow ? memQ[0] : 32'h0;
    imem_rvalid = rvNow;
    imem_rdata  = rvNow ? (headPc ^ KEY) : $urandom;
    gnt         = ($urandom_range(99) < gntProb);
    imem_gnt    = gnt;
    #1;
    reqExp  = !rd && (bufPcQ.size() == 0) &&
              ((memQ.size() == 0) || (!mSquash && rvNow && !st));
    reqAct  = imem_req;
    addrAct = imem_addr;
    check32("imem_req", {31'b0, reqAct}, {31'b0, reqExp});
    if (reqExp && gnt) check32("imem_addr", addrAct, expFetch);
    @(posedge clk);

    if (rd) begin
      expFetch = {rpc[31:2], 2'b00};
      bufInstrQ.delete();
      bufPcQ.delete();
      expValid = 1'b0;
      expInstr = NOP;
      mSquash  = (memQ.size() > 0) && !rvNow;
    end else begin
      respGood = rvNow && !mSquash;
      if (rvNow) mSquash = 1'b0;
      if (reqExp && gnt) expFetch = expFetch + 32'd4;
      if (st) begin
        if (respGood) begin
          bufInstrQ.push_back(headPc ^ KEY);
          bufPcQ.push_back(headPc);
        end
      end else if (bufPcQ.size() > 0) begin
        expInstr = bufInstrQ.pop_front();
        expPc    = bufPcQ.pop_front();
        expValid = 1'b1;
      end else if (respGood) begin
        expInstr = headPc ^ KEY;
        expPc    = headPc;
        expValid = 1'b1;
      end else begin
        expInstr = NOP;
        expValid = 1'b0;
      end
    end

    if (rvNow) void'(memQ.pop_front());
    if (reqAct && gnt) begin
      memQ.push_back(addrAct);
      memWait = $urandom_range(latMax, latMin);
    end else if (memQ.size() > 0 && memWait > 0) begin
      memWait--;
    end

    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic runUntilValid(input int bound, output int n);
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      n++;
    end while (!expValid && n < bound);
    check32("valid within bound", {31'b0, valid}, 32'd1);
  endtask

  task automatic runUntilOutstanding(input int bound);
    int n;
    n = 0;
    while (!(memQ.size() > 0 && memWait > 0) && n < bound) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      n++;
    end
  endtask

  initial begin
    int n;
    bit st;
    bit rd;
    compared   = 0;
    mismatched = 0;
    gntProb    = 100;
    latMin     = 0;
    latMax     = 0;
    doReset();

    $display("[TB] zero-wait streaming from reset");
    applyStimulus(1'b0, 1'b0, 32'h0);
    check32("first edge valid", {31'b0, valid}, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("stream valid", {31'b0, valid}, 32'd1);
      check32("stream pc", pc_address, 32'((k - 2) * 4));
      check32("stream instr", instruction, 32'((k - 2) * 4) ^ KEY);
    end

    $display("[TB] stall while 0x10 returns");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      check32("stall hold pc", pc_address, 32'h0000_000C);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    check32("buffered pc", pc_address, 32'h0000_0010);
    check32("buffered valid", {31'b0, valid}, 32'd1);
    runUntilValid(8, n);
    check32("after buffer pc", pc_address, 32'h0000_0014);

    $display("[TB] redirect with request outstanding");
    latMin = 3;
    latMax = 3;
    runUntilOutstanding(10);
    applyStimulus(1'b0, 1'b1, 32'h0000_0203);
    check32("redirect valid", {31'b0, valid}, 32'd0);
    runUntilValid(20, n);
    check32("redirect target pc", pc_address, 32'h0000_0200);
    check32("redirect target instr", instruction, 32'h0000_0200 ^ KEY);

    $display("[TB] redirect and stall with buffer full");
    latMin = 0;
    latMax = 0;
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    n = 0;
    while (bufPcQ.size() == 0 && n < 10) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      n++;
    end
    applyStimulus(1'b1, 1'b1, 32'h0000_0400);
    check32("redirect+stall valid", {31'b0, valid}, 32'd0);
    runUntilValid(10, n);
    check32("redirect+stall pc", pc_address, 32'h0000_0400);

    $display("[TB] address wrap");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
    runUntilValid(10, n);
    check32("redirect penalty", n, 32'd2);
    check32("wrap last pc", pc_address, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    check32("wrap first pc", pc_address, 32'h0000_0000);
    check32("wrap valid", {31'b0, valid}, 32'd1);

    $display("[TB] asynchronous reset mid-fetch");
    latMin = 3;
    latMax = 3;
    runUntilOutstanding(10);
    rst = 1'b1;
    #1;
    check32("async rst imem_req", {31'b0, imem_req}, 32'd0);
    check32("async rst valid", {31'b0, valid}, 32'd0);
    check32("async rst instr", instruction, NOP);
    latMin = 0;
    latMax = 0;
    doReset();
    runUntilValid(10, n);
    check32("post-reset pc", pc_address, RPC);

    $display("[TB] randomized traffic");
    gntProb = 70;
    latMin  = 0;
    latMax  = 3;
    for (int k = 0; k < 400; k++) begin
      st = ($urandom_range(99) < 20);
      rd = ($urandom_range(99) < 8);
      applyStimulus(st, rd, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
